bus_mux_reg: RTL and testbench
==============================

BUS_MUX_REG -- requirements
Module: bus_mux_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, bus data width in bits.
REQ-002 SHALL have parameter NSRC, default 24, number of bus sources (2..32).
REQ-003 SHALL have parameter HOLD_LAST, default 1; 1 = bus_q retains its value when idle, 0 = bus_q clears to 0 when idle.
REQ-004 SHALL have port clk, input, 1, single clock, rising-edge.
REQ-005 SHALL have port clr, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port src_data, input, NSRC*WIDTH, source i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port src_out, input, NSRC, per-source drive request (one-hot intended).
REQ-008 SHALL have port conflict_clr, input, 1, clears conflict_sticky.
REQ-009 SHALL have port bus_q, output, WIDTH, registered bus value.
REQ-010 SHALL have port bus_valid, output, 1, high for the cycle after a transfer was captured.
REQ-011 SHALL have port sel_q, output, 5, index of the captured source.
REQ-012 SHALL have port conflict, output, 1, one-cycle pulse: more than one src_out bit was high.
REQ-013 SHALL have port conflict_sticky, output, 1, latched conflict flag.
REQ-014 SHALL have port xfer_count, output, 16, count of captured transfers.

Function
REQ-015 SHALL select the lowest-index asserted src_out bit (fixed priority, index 0 highest).
REQ-016 SHALL, on each rising clk edge with any src_out bit high, load bus_q with the selected source data, sel_q with its index, and set bus_valid to 1; latency is exactly one cycle.
REQ-017 SHALL, on an edge with src_out all zero, set bus_valid to 0, hold sel_q, and either hold bus_q (HOLD_LAST=1) or load 0 (HOLD_LAST=0).
REQ-018 SHALL set conflict to 1 for exactly the cycle after an edge at which two or more src_out bits were high; the lowest-index source is still captured.
REQ-019 SHALL set conflict_sticky on a conflict and clear it on conflict_clr; when both occur on the same edge, set wins.
REQ-020 SHALL increment xfer_count on each edge at which a transfer is captured, and saturate at 16'hFFFF without wrapping.
REQ-021 SHALL ignore src_out bits at or above NSRC, which do not exist.

Reset
REQ-022 SHALL, while clr is low, asynchronously force bus_q=0, bus_valid=0, sel_q=0, conflict=0, conflict_sticky=0, xfer_count=0.
REQ-023 SHALL resume normal capture on the first rising edge after clr deasserts; a transfer requested during reset is discarded and not counted.

Structure
REQ-024 SHALL take source-index constants from shared package bus_pkg:
- R0..R15 = 0..15, HI = 16, LO = 17, ZHI = 18, ZLO = 19, PC = 20, MDR = 21, INPORT = 22, CSIGN = 23.
- Package also holds BUS_W = 32 and SEL_W = 5.
REQ-025 SHALL implement the priority encode and multi-hot detect as the combinational sub-module bus_src_encoder (outputs: idx, any, multi).
REQ-026 SHALL keep all state in bus_mux_reg; there are no latches and no combinational path from src_out to any output.

Verification
REQ-027 Bench SHALL cover these scenarios:
- Reset check: hold clr low, drive src_out=1<<20 with PC data 32'h0000_0040 -> every output 0; after release, next edge -> bus_q=32'h40, sel_q=20, bus_valid=1, xfer_count=1.
- Single source sweep: for i=0..23, assert src_out=1<<i with data i*32'h0101_0101 -> one cycle later bus_q=i*32'h0101_0101, sel_q=i.
- Conflict: src_out = bits 3 and 17 -> bus_q=R3 data, conflict=1 for one cycle, conflict_sticky=1; conflict_clr then clears sticky; conflict and conflict_clr on the same edge -> sticky remains 1.
- Idle behaviour: transfer 32'hDEADBEEF then src_out=0 -> HOLD_LAST=1 gives bus_q=32'hDEADBEEF and bus_valid=0; HOLD_LAST=0 gives bus_q=0.
- Counter saturation: 65537 consecutive transfers -> xfer_count=16'hFFFF and stays there.
- Parametrisation: WIDTH=16, NSRC=4, src_out=4'b1000 with data 16'hA5A5 -> bus_q=16'hA5A5, sel_q=3.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus constants: source indices and widths for the single-bus register mux.
package bus_pkg;

  localparam int BUS_W = 32;
  localparam int SEL_W = 5;
  localparam int CNT_W = 16;

  localparam logic [SEL_W-1:0] R0     = 5'd0;
  localparam logic [SEL_W-1:0] R1     = 5'd1;
  localparam logic [SEL_W-1:0] R2     = 5'd2;
  localparam logic [SEL_W-1:0] R3     = 5'd3;
  localparam logic [SEL_W-1:0] R4     = 5'd4;
  localparam logic [SEL_W-1:0] R5     = 5'd5;
  localparam logic [SEL_W-1:0] R6     = 5'd6;
  localparam logic [SEL_W-1:0] R7     = 5'd7;
  localparam logic [SEL_W-1:0] R8     = 5'd8;
  localparam logic [SEL_W-1:0] R9     = 5'd9;
  localparam logic [SEL_W-1:0] R10    = 5'd10;
  localparam logic [SEL_W-1:0] R11    = 5'd11;
  localparam logic [SEL_W-1:0] R12    = 5'd12;
  localparam logic [SEL_W-1:0] R13    = 5'd13;
  localparam logic [SEL_W-1:0] R14    = 5'd14;
  localparam logic [SEL_W-1:0] R15    = 5'd15;
  localparam logic [SEL_W-1:0] HI     = 5'd16;
  localparam logic [SEL_W-1:0] LO     = 5'd17;
  localparam logic [SEL_W-1:0] ZHI    = 5'd18;
  localparam logic [SEL_W-1:0] ZLO    = 5'd19;
  localparam logic [SEL_W-1:0] PC     = 5'd20;
  localparam logic [SEL_W-1:0] MDR    = 5'd21;
  localparam logic [SEL_W-1:0] INPORT = 5'd22;
  localparam logic [SEL_W-1:0] CSIGN  = 5'd23;

endpackage

// File: rtl/bus_src_encoder.sv
// Fixed-priority encoder over the drive requests (index 0 wins) with multi-driver detect.
module bus_src_encoder
  import bus_pkg::*;
#(
  parameter int NSRC = 24
) (
  input  logic [NSRC-1:0]  src,
  output logic [SEL_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  always_comb begin
    idx = '0;
    // Scan downward so the lowest set index is the last one written.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src[i]) idx = SEL_W'(i);
    end
  end

  assign any   = |src;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(src & (src - NSRC'(1)));

endmodule

// File: rtl/bus_mux_reg.sv
// Registered single-bus multiplexer with transfer counter and conflict reporting.
module bus_mux_reg
  import bus_pkg::*;
#(
  parameter int WIDTH     = BUS_W,
  parameter int NSRC      = 24,
  parameter int HOLD_LAST = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       src_out,
  input  logic                  conflict_clr,
  output logic [WIDTH-1:0]      bus_q,
  output logic                  bus_valid,
  output logic [SEL_W-1:0]      sel_q,
  output logic                  conflict,
  output logic                  conflict_sticky,
  output logic [CNT_W-1:0]      xfer_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  logic [SEL_W-1:0] idx_p0;
  logic             any_p0;
  logic             multi_p0;
  logic [WIDTH-1:0] data_p0;

  bus_src_encoder #(.NSRC(NSRC)) u_enc (
    .src   (src_out),
    .idx   (idx_p0),
    .any   (any_p0),
    .multi (multi_p0)
  );

  always_comb begin
    data_p0 = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (idx_p0 == SEL_W'(i)) data_p0 = src_data[i*WIDTH +: WIDTH];
    end
  end

  // p0 -> p1: capture stage, every output comes straight from these registers
  logic [WIDTH-1:0] bus_p1;
  logic [SEL_W-1:0] sel_p1;
  logic             vld_p1;
  logic             conf_p1;
  logic             sticky_p1;
  logic [CNT_W-1:0] cnt_p1;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      bus_p1    <= '0;
      sel_p1    <= '0;
      vld_p1    <= 1'b0;
      conf_p1   <= 1'b0;
      sticky_p1 <= 1'b0;
      cnt_p1    <= '0;
    end else begin
      vld_p1  <= any_p0;
      conf_p1 <= multi_p0;
      if (any_p0) begin
        bus_p1 <= data_p0;
        sel_p1 <= idx_p0;
        cnt_p1 <= sat_inc(cnt_p1);
      end else if (HOLD_LAST == 0) begin
        bus_p1 <= '0;
      end
      if (multi_p0)          sticky_p1 <= 1'b1;
      else if (conflict_clr) sticky_p1 <= 1'b0;
    end
  end

  assign bus_q           = bus_p1;
  assign sel_q           = sel_p1;
  assign bus_valid       = vld_p1;
  assign conflict        = conf_p1;
  assign conflict_sticky = sticky_p1;
  assign xfer_count      = cnt_p1;

endmodule

// File: tb/tb_bus_mux_reg.sv
// Randomized bench for bus_mux_reg against a cycle-level behavioural model.
module tb_bus_mux_reg;
  import bus_pkg::*;

  localparam int NS = 24;

  logic          clk = 1'b0;
  logic          clr;
  logic [NS*32-1:0] src_data;
  logic [NS-1:0] src_out;
  logic          conflict_clr;
  logic [31:0]   dat [NS];

  logic [31:0] bus_q, bus_q0;
  logic        bus_valid, bus_valid0, conflict, conflict0, sticky, sticky0;
  logic [4:0]  sel_q, sel_q0;
  logic [15:0] xfer_count, xfer_count0;

  logic [63:0] sd16;
  logic [3:0]  so16;
  logic [15:0] bus16, cnt16;
  logic [4:0]  sel16;
  logic        vld16, conf16, sticky16;

  always #5 clk = ~clk;

  bus_mux_reg #(.WIDTH(32), .NSRC(NS), .HOLD_LAST(1)) dut (
    .clk(clk), .clr(clr), .src_data(src_data), .src_out(src_out),
    .conflict_clr(conflict_clr), .bus_q(bus_q), .bus_valid(bus_valid),
    .sel_q(sel_q), .conflict(conflict), .conflict_sticky(sticky),
    .xfer_count(xfer_count));

  bus_mux_reg #(.WIDTH(32), .NSRC(NS), .HOLD_LAST(0)) dut_h0 (
    .clk(clk), .clr(clr), .src_data(src_data), .src_out(src_out),
    .conflict_clr(conflict_clr), .bus_q(bus_q0), .bus_valid(bus_valid0),
    .sel_q(sel_q0), .conflict(conflict0), .conflict_sticky(sticky0),
    .xfer_count(xfer_count0));

  bus_mux_reg #(.WIDTH(16), .NSRC(4), .HOLD_LAST(1)) dut_w16 (
    .clk(clk), .clr(clr), .src_data(sd16), .src_out(so16),
    .conflict_clr(1'b0), .bus_q(bus16), .bus_valid(vld16),
    .sel_q(sel16), .conflict(conf16), .conflict_sticky(sticky16),
    .xfer_count(cnt16));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural model state
  logic [31:0] m_bus, m_bus0;
  logic [4:0]  m_sel;
  logic        m_vld, m_conf, m_sticky;
  int          m_cnt;
  logic [15:0] m16_bus;
  logic [4:0]  m16_sel;

  function automatic int lowest(input logic [NS-1:0] v);
    for (int i = 0; i < NS; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_bus = 0; m_bus0 = 0; m_sel = 0; m_vld = 0; m_conf = 0; m_sticky = 0; m_cnt = 0;
    m16_bus = 0; m16_sel = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) src_data[i*32 +: 32] = dat[i];
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".bus"}, bus_q, m_bus);
    chk({tag, ".bus_h0"}, bus_q0, m_bus0);
    chk({tag, ".sel"}, {27'd0, sel_q}, {27'd0, m_sel});
    chk({tag, ".vld"}, {31'd0, bus_valid}, {31'd0, m_vld});
    chk({tag, ".conf"}, {31'd0, conflict}, {31'd0, m_conf});
    chk({tag, ".sticky"}, {31'd0, sticky}, {31'd0, m_sticky});
    chk({tag, ".cnt"}, {16'd0, xfer_count}, m_cnt);
  endtask

  task automatic step(input string tag, input bit do_chk);
    int k, k16;
    drive();
    k = lowest(src_out);
    if (k >= 0) begin
      m_bus = dat[k]; m_bus0 = dat[k]; m_sel = 5'(k); m_vld = 1;
      if (m_cnt < 65535) m_cnt++;
    end else begin
      m_vld = 0; m_bus0 = 0;
    end
    m_conf = ($countones(src_out) > 1);
    if (m_conf) m_sticky = 1;
    else if (conflict_clr) m_sticky = 0;
    k16 = -1;
    for (int i = 3; i >= 0; i--) if (so16[i]) k16 = i;
    if (k16 >= 0) begin
      m16_bus = sd16[k16*16 +: 16]; m16_sel = 5'(k16);
    end
    @(posedge clk); #1;
    if (do_chk) begin
      check_all(tag);
      chk({tag, ".bus16"}, {16'd0, bus16}, {16'd0, m16_bus});
      chk({tag, ".sel16"}, {27'd0, sel16}, {27'd0, m16_sel});
    end
  endtask

  initial begin
    clr = 1'b0; conflict_clr = 1'b0; so16 = '0; sd16 = '0;
    for (int i = 0; i < NS; i++) dat[i] = $urandom;
    dat[PC] = 32'h0000_0040;
    src_out = NS'(1) << PC;
    drive();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.bus16", {16'd0, bus16}, 32'd0);

    clr = 1'b1;
    step("rst_rel", 1);
    chk("rst_rel.bus_const", bus_q, 32'h40);
    chk("rst_rel.sel_const", {27'd0, sel_q}, 32'd20);
    chk("rst_rel.cnt_const", {16'd0, xfer_count}, 32'd1);

    // Single-source sweep
    for (int i = 0; i < NS; i++) begin
      for (int j = 0; j < NS; j++) dat[j] = $urandom;
      dat[i] = i * 32'h0101_0101;
      src_out = NS'(1) << i;
      step("sweep", 1);
      chk("sweep.bus_const", bus_q, i * 32'h0101_0101);
    end

    // Conflict and sticky flag
    src_out = (NS'(1) << R3) | (NS'(1) << LO);
    step("conf", 1);
    chk("conf.bus_r3", bus_q, dat[R3]);
    chk("conf.pulse", {31'd0, conflict}, 32'd1);
    src_out = '0; conflict_clr = 1'b1;
    step("conf_clr", 1);
    chk("conf_clr.sticky", {31'd0, sticky}, 32'd0);
    src_out = (NS'(1) << 5) | (NS'(1) << 9);
    step("conf_both", 1);
    chk("conf_both.sticky", {31'd0, sticky}, 32'd1);
    conflict_clr = 1'b0;

    // Idle behaviour
    dat[MDR] = 32'hDEAD_BEEF; src_out = NS'(1) << MDR;
    step("idle_load", 1);
    src_out = '0;
    step("idle", 1);
    chk("idle.hold", bus_q, 32'hDEAD_BEEF);
    chk("idle.clear_h0", bus_q0, 32'd0);
    chk("idle.vld", {31'd0, bus_valid}, 32'd0);

    // Narrow instance
    sd16 = {16'hA5A5, 16'h1111, 16'h2222, 16'h3333}; so16 = 4'b1000;
    step("w16", 1);
    chk("w16.bus_const", {16'd0, bus16}, 32'h0000_A5A5);
    chk("w16.sel_const", {27'd0, sel16}, 32'd3);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      int mode;
      for (int j = 0; j < NS; j++) dat[j] = $urandom;
      sd16 = {$urandom, $urandom};
      so16 = 4'($urandom);
      mode = $urandom_range(0, 3);
      if (mode == 0)      src_out = '0;
      else if (mode == 1) src_out = NS'(1) << $urandom_range(0, NS - 1);
      else                src_out = NS'($urandom);
      conflict_clr = ($urandom_range(0, 3) == 0);
      step("rand", 1);
    end
    conflict_clr = 1'b0;

    // Counter saturation: 65537 consecutive transfers
    for (int n = 0; n < 65537; n++) begin
      src_out = NS'(1) << $urandom_range(0, NS - 1);
      dat[lowest(src_out)] = $urandom;
      step("sat", (n % 8192) == 0);
    end
    chk("sat.cnt_const", {16'd0, xfer_count}, 32'h0000_FFFF);
    for (int n = 0; n < 4; n++) begin
      src_out = NS'(1) << $urandom_range(0, NS - 1);
      step("sat_hold", 1);
    end
    chk("sat_hold.cnt_const", {16'd0, xfer_count}, 32'h0000_FFFF);

    // Asynchronous reset mid-cycle
    src_out = NS'(1) << R7;
    #2 clr = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk); #1;
    check_all("async_rst_hold");
    clr = 1'b1;
    step("post_rst", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
